// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard.
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_NONE   = 2'd0,
    HZ_STALL  = 2'd1,
    HZ_FLUSH  = 2'd2,
    HZ_FREEZE = 2'd3
  } hazard_op_e;

  // Counter width able to hold the values 0..depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_sb_cnt.sv
// Countdown counter for one tracked register: loads WB_DEPTH on issue, counts to zero.
module hazard_sb_cnt
  import hazard_pkg::*;
#(
  parameter int unsigned WB_DEPTH = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_en_i,
  output logic busy_o
);

  localparam int unsigned CntW = cnt_width(WB_DEPTH);

  logic [CntW-1:0] cnt_q, cnt_d;

  // A load replaces the decrement so the newest writer wins.
  always_comb begin
    cnt_d = cnt_q;
    if (dec_en_i) begin
      if (load_i) begin
        cnt_d = CntW'(WB_DEPTH);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based RAW hazard detector with branch flush and external freeze.
// Optional HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned WB_DEPTH     = 3,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                id_valid_i,
  input  logic [ADDR_W-1:0]   r1_addr_id_i,
  input  logic [ADDR_W-1:0]   r2_addr_id_i,
  input  logic                r1_used_i,
  input  logic                r2_used_i,
  input  logic [ADDR_W-1:0]   rd_addr_id_i,
  input  logic                rd_wren_id_i,
  input  logic                br_sel_i,
  input  logic                freeze_i,
  output logic [1:0]          hazard_op_o,
  output logic                stall_o,
  output logic                flush_o,
  output logic [NUM_REGS-1:0] busy_regs_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]         stall_cnt_o,
  output logic [31:0]         flush_cnt_o
`endif
);

  logic [NUM_REGS-1:0] busy;
  logic [1:0]          flush_tmr_q, flush_tmr_d;
  logic                flush_act;
  logic                r1_busy, r2_busy, raw, issue;
  hazard_op_e          op;

  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    hazard_sb_cnt #(
      .WB_DEPTH (WB_DEPTH)
    ) u_cnt (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load_i   (issue && (rd_addr_id_i == ADDR_W'(r))),
      .dec_en_i (!freeze_i),
      .busy_o   (busy[r])
    );
  end

  assign busy_regs_o = busy;

  assign r1_busy = (r1_addr_id_i != '0) && (32'(r1_addr_id_i) < NUM_REGS) && busy[r1_addr_id_i];
  assign r2_busy = (r2_addr_id_i != '0) && (32'(r2_addr_id_i) < NUM_REGS) && busy[r2_addr_id_i];
  assign raw     = id_valid_i && ((r1_used_i && r1_busy) || (r2_used_i && r2_busy));

  // A branch is ignored under freeze because EX is held and will reassert it.
  assign flush_act = (br_sel_i && !freeze_i) || (flush_tmr_q != '0);

  always_comb begin
    op      = HZ_NONE;
    stall_o = 1'b0;
    flush_o = 1'b0;
    if (freeze_i) begin
      op      = HZ_FREEZE;
      stall_o = 1'b1;
    end else if (flush_act) begin
      op      = HZ_FLUSH;
      flush_o = 1'b1;
    end else if (raw) begin
      op      = HZ_STALL;
      stall_o = 1'b1;
    end
  end

  assign hazard_op_o = op;
  assign issue = id_valid_i && rd_wren_id_i && (rd_addr_id_i != '0) && (op == HZ_NONE);

  always_comb begin
    flush_tmr_d = flush_tmr_q;
    if (!freeze_i) begin
      if (br_sel_i) begin
        flush_tmr_d = 2'(FLUSH_CYCLES - 1);
      end else if (flush_tmr_q != '0) begin
        flush_tmr_d = flush_tmr_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flush_tmr_q <= '0;
    end else begin
      flush_tmr_q <= flush_tmr_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (op == HZ_STALL && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
    if (op == HZ_FLUSH && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed vectors push expectations, a monitor compares.
module tb_hazard_scoreboard;

  localparam int unsigned NUM_REGS     = 32;
  localparam int unsigned ADDR_W       = 5;
  localparam int unsigned WB_DEPTH     = 3;
  localparam int unsigned FLUSH_CYCLES = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                id_valid = 1'b0;
  logic [ADDR_W-1:0]   r1_addr = '0, r2_addr = '0, rd_addr = '0;
  logic                r1_used = 1'b0, r2_used = 1'b0, rd_wren = 1'b0;
  logic                br_sel = 1'b0, freeze = 1'b0;
  logic [1:0]          hazard_op;
  logic                stall, flush;
  logic [NUM_REGS-1:0] busy_regs;
`ifdef HAZARD_PERF_EN
  logic [31:0]         stall_cnt, flush_cnt;
`endif

  hazard_scoreboard #(
    .NUM_REGS     (NUM_REGS),
    .ADDR_W       (ADDR_W),
    .WB_DEPTH     (WB_DEPTH),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .id_valid_i   (id_valid),
    .r1_addr_id_i (r1_addr),
    .r2_addr_id_i (r2_addr),
    .r1_used_i    (r1_used),
    .r2_used_i    (r2_used),
    .rd_addr_id_i (rd_addr),
    .rd_wren_id_i (rd_wren),
    .br_sel_i     (br_sel),
    .freeze_i     (freeze),
    .hazard_op_o  (hazard_op),
    .stall_o      (stall),
    .flush_o      (flush),
    .busy_regs_o  (busy_regs)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt_o  (stall_cnt),
    .flush_cnt_o  (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [1:0]  op;
    logic [31:0] busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
  endtask

  function automatic logic [31:0] bit_of(input int n);
    return 32'd1 << n;
  endfunction

  // One cycle of stimulus with its hand-computed expected outputs.
  task automatic step(input string nm, input logic r, input logic v,
                      input logic [4:0] a1, input logic u1, input logic [4:0] a2, input logic u2,
                      input logic [4:0] d, input logic w, input logic br, input logic fz,
                      input logic [1:0] eop, input logic [31:0] ebusy);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; r1_addr = a1; r1_used = u1; r2_addr = a2; r2_used = u2;
    rd_addr = d; rd_wren = w; br_sel = br; freeze = fz;
    e.name = nm; e.rst = r; e.op = eop; e.busy = ebusy;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic [31:0] ebusy);
    step(nm, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, ebusy);
  endtask

  // Monitor: expected perf counts are accumulated from the expected ops already seen.
  int unsigned exp_stall_cnt = 0;
  int unsigned exp_flush_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.rst) begin
        exp_stall_cnt = 0;
        exp_flush_cnt = 0;
      end
      chk({e.name, ".op"}, 32'(hazard_op), 32'(e.op));
      chk({e.name, ".stall"}, 32'(stall), 32'((e.op == 2'd1) || (e.op == 2'd3)));
      chk({e.name, ".flush"}, 32'(flush), 32'(e.op == 2'd2));
      chk({e.name, ".busy"}, busy_regs, e.busy);
`ifdef HAZARD_PERF_EN
      chk({e.name, ".stall_cnt"}, stall_cnt, exp_stall_cnt);
      chk({e.name, ".flush_cnt"}, flush_cnt, exp_flush_cnt);
`endif
      if (!e.rst && e.op == 2'd1) exp_stall_cnt++;
      if (!e.rst && e.op == 2'd2) exp_flush_cnt++;
    end
  end

  always @(negedge clk) begin
    if (!rst && !freeze) begin
      assert (!(flush && stall)) else $error("FAIL flush_and_stall: both high without freeze");
    end
  end

  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt_chk
    always @(negedge clk) begin
      assert (int'(dut.g_cnt[gi].u_cnt.cnt_q) <= int'(WB_DEPTH))
        else $error("FAIL cnt_bound: reg %0d count %0d", gi, dut.g_cnt[gi].u_cnt.cnt_q);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held, then released.
    step("rst_hold0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 32'd0);
    step("rst_hold1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 32'd0);
    idle("rst_idle", 32'd0);

    // Dependent pair: 3 stall cycles, dependent issues on the 4th.
    step("dep_issue", 0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 2'd0, 32'd0);
    step("dep_s1",    0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 2'd1, bit_of(5));
    step("dep_s2",    0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 2'd1, bit_of(5));
    step("dep_s3",    0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 2'd1, bit_of(5));
    step("dep_go",    0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 2'd0, 32'd0);
    idle("dep_d1", bit_of(6));
    idle("dep_d2", bit_of(6));
    idle("dep_d3", bit_of(6));
    idle("dep_d4", 32'd0);

    // x0 is never tracked.
    step("x0_wr", 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 32'd0);
    step("x0_rd", 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 2'd0, 32'd0);

    // Taken branch while ID stalls on x7; two flush cycles; flushed ID leaves no entry.
    step("br_iss7", 0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 2'd0, 32'd0);
    step("br_stl",  0, 1, 7, 1, 0, 0, 8, 1, 0, 0, 2'd1, bit_of(7));
    step("br_fl1",  0, 1, 7, 1, 0, 0, 8, 1, 1, 0, 2'd2, bit_of(7));
    step("br_fl2",  0, 1, 7, 1, 0, 0, 8, 1, 0, 0, 2'd2, bit_of(7));
    step("br_go",   0, 1, 7, 1, 0, 0, 8, 1, 0, 0, 2'd0, 32'd0);
    idle("br_d1", bit_of(8));
    idle("br_d2", bit_of(8));
    idle("br_d3", bit_of(8));
    idle("br_d4", 32'd0);

    // Freeze with cnt[3]=2: counters hold, branch ignored, stall resumes for 2 cycles.
    step("fz_iss3", 0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 2'd0, 32'd0);
    step("fz_stl",  0, 1, 0, 0, 3, 1, 0, 0, 0, 0, 2'd1, bit_of(3));
    step("fz_h1",   0, 1, 0, 0, 3, 1, 0, 0, 0, 1, 2'd3, bit_of(3));
    step("fz_h2",   0, 1, 0, 0, 3, 1, 0, 0, 1, 1, 2'd3, bit_of(3));
    step("fz_h3",   0, 1, 0, 0, 3, 1, 0, 0, 0, 1, 2'd3, bit_of(3));
    step("fz_h4",   0, 1, 0, 0, 3, 1, 0, 0, 0, 1, 2'd3, bit_of(3));
    step("fz_p1",   0, 1, 0, 0, 3, 1, 0, 0, 0, 0, 2'd1, bit_of(3));
    step("fz_p2",   0, 1, 0, 0, 3, 1, 0, 0, 0, 0, 2'd1, bit_of(3));
    step("fz_done", 0, 1, 0, 0, 3, 1, 0, 0, 0, 0, 2'd0, 32'd0);

    // WAW on x9; an unused source on a busy register must not stall.
    step("waw_1",  0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 2'd0, 32'd0);
    step("waw_2",  0, 1, 9, 0, 0, 0, 9, 1, 0, 0, 2'd0, bit_of(9));
    step("waw_s1", 0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 2'd1, bit_of(9));
    step("waw_s2", 0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 2'd1, bit_of(9));
    step("waw_s3", 0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 2'd1, bit_of(9));
    step("waw_go", 0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 2'd0, 32'd0);

    // Asynchronous reset in the middle of a stall with cnt[5]=2.
    step("mr_iss5", 0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 2'd0, 32'd0);
    step("mr_stl",  0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 2'd1, bit_of(5));
    step("mr_rst",  1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 2'd0, 32'd0);
    step("mr_post", 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 2'd0, 32'd0);
    idle("end_idle", 32'd0);

    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
